// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble conversion of an 8-bit value to two packed BCD digits with overflow flag
module bin_to_bcd_seq #(
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd,
    output logic       ovf
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      r_state;
    logic [7:0]  r_sh;
    logic [1:0]  r_h;
    logic [3:0]  r_t;
    logic [3:0]  r_u;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_bcd;
    logic        r_ovf;
    logic [3:0]  w_t_adj;
    logic [3:0]  w_u_adj;
    logic [17:0] w_next;
    logic        w_ovf;
    // w_next packs {h, t, u, shreg} after correction and one left shift
    always_comb begin
        w_t_adj = (r_t >= 4'd5) ? r_t + 4'd3 : r_t;
        w_u_adj = (r_u >= 4'd5) ? r_u + 4'd3 : r_u;
        w_next  = {r_h[0], w_t_adj, w_u_adj, r_sh, 1'b0};
        w_ovf   = w_next[17:16] != 2'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= 8'd0;
            r_h     <= 2'd0;
            r_t     <= 4'd0;
            r_u     <= 4'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= 8'h00;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_sh    <= bin;
                    r_h     <= 2'd0;
                    r_t     <= 4'd0;
                    r_u     <= 4'd0;
                    r_cnt   <= 3'd0;
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
            end else begin
                {r_h, r_t, r_u, r_sh} <= w_next;
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_ovf   <= w_ovf;
                    r_bcd   <= (w_ovf && SATURATE) ? 8'h99 : w_next[15:8];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench driving saturating and wrapping converters in lockstep
module tb_bin_to_bcd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1;
    logic [7:0] bin = 8'd45;
    logic       busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
    logic [7:0] bcd_s, bcd_w;
    int         checks = 0;
    int         failures = 0;
    logic [17:0] q[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_s), .done(done_s), .bcd(bcd_s), .ovf(ovf_s)
    );
    bin_to_bcd_seq #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_w), .done(done_w), .bcd(bcd_w), .ovf(ovf_w)
    );

    // {ovf_sat, ovf_wrap, bcd_sat, bcd_wrap} from plain decimal arithmetic
    function automatic logic [17:0] expv(input int v);
        int         m = v % 100;
        logic       o = v > 99;
        logic [7:0] w = {4'(m / 10), 4'(m % 10)};
        return {o, o, o ? 8'h99 : w, w};
    endfunction

    function automatic logic [17:0] cur();
        return {ovf_s, ovf_w, bcd_s, bcd_w};
    endfunction

    // inputs change and outputs are sampled on falling edges; sample k lies between accept edge E(k-1) and Ek
    task automatic convert(input logic [7:0] v, output int lat, output int nbusy,
                           output logic [17:0] got, output logic [17:0] exp);
        @(negedge clk);
        bin = v;
        start = 1'b1;
        q.push_back(expv(int'(v)));
        lat = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy_s && busy_w) nbusy++;
        end while (!(done_s && done_w) && lat < 30);
        got = cur();
        exp = q.pop_front();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_s, done_s, ovf_s, bcd_s, busy_w, done_w, ovf_w, bcd_w} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state: got s=%b%b%b%h w=%b%b%b%h want all zero",
                     busy_s, done_s, ovf_s, bcd_s, busy_w, done_w, ovf_w, bcd_w);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || busy_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_start: busy=%b/%b want 0", busy_s, busy_w);
        end
    endtask

    task automatic test_basic();
        int lat, nb;
        logic [17:0] g, e;
        convert(8'd45, lat, nb, g, e);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL basic_latency: done at sample %0d want 9", lat);
        end
        checks++;
        if (nb !== 8) begin
            failures++;
            $display("FAIL basic_busy: busy for %0d cycles want 8", nb);
        end
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL basic_45: got %h want %h", g, e);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bcd_s !== 8'h45 || done_s !== 1'b0 || busy_s !== 1'b0) begin
                failures++;
                $display("FAIL basic_hold: bcd=%h done=%b busy=%b want 45/0/0", bcd_s, done_s, busy_s);
            end
        end
    endtask

    task automatic test_values();
        logic [7:0] vals[4] = '{8'd99, 8'd0, 8'd100, 8'd255};
        int lat, nb;
        logic [17:0] g, e;
        foreach (vals[i]) begin
            convert(vals[i], lat, nb, g, e);
            checks++;
            if (g !== e || lat !== 9) begin
                failures++;
                $display("FAIL value_%0d: got %h at %0d want %h at 9", vals[i], g, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int m = 0;
        int dones = 0;
        logic [17:0] e;
        @(negedge clk);
        bin = 8'd37;
        start = 1'b1;
        q.push_back(expv(37));
        do begin
            @(negedge clk);
            n++;
            start = (n == 3);
            if (n == 3) bin = 8'd80;
        end while (!done_s && n < 30);
        e = q.pop_front();
        checks++;
        if (cur() !== e || n !== 9) begin
            failures++;
            $display("FAIL busy_start_ignored: got %h at %0d want %h at 9", cur(), n, e);
        end
        bin = 8'd12;
        start = 1'b1;
        q.push_back(expv(12));
        do begin
            @(negedge clk);
            start = 1'b0;
            m++;
        end while (!done_s && m < 30);
        e = q.pop_front();
        checks++;
        if (cur() !== e || m !== 9) begin
            failures++;
            $display("FAIL done_cycle_start: got %h at %0d want %h at 9", cur(), m, e);
        end
        repeat (12) begin
            @(negedge clk);
            if (done_s || busy_s) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL no_queued_start: %0d busy/done cycles want 0", dones);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat, nb;
        logic [17:0] g, e;
        @(negedge clk);
        bin = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bin = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy_s, done_s, ovf_s, bcd_s, busy_w, done_w, ovf_w, bcd_w} !== 22'd0) begin
            failures++;
            $display("FAIL abort_state: got s=%b%b%b%h w=%b%b%b%h want all zero",
                     busy_s, done_s, ovf_s, bcd_s, busy_w, done_w, ovf_w, bcd_w);
        end
        repeat (12) begin
            @(negedge clk);
            if (done_s || done_w || bcd_s !== 8'h00) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d bad cycles want 0", dones);
        end
        convert(8'd7, lat, nb, g, e);
        checks++;
        if (g !== e || lat !== 9) begin
            failures++;
            $display("FAIL after_abort_7: got %h at %0d want %h at 9", g, lat, e);
        end
    endtask

    task automatic test_exhaustive();
        int next = 1;
        int n = 0;
        int total = 0;
        int seen = 0;
        logic [17:0] e;
        @(negedge clk);
        bin = 8'd0;
        start = 1'b1;
        q.push_back(expv(0));
        while (seen < 256 && total < 256 * 9 + 40) begin
            @(negedge clk);
            n++;
            total++;
            if (done_s) begin
                e = q.pop_front();
                checks++;
                if (cur() !== e) begin
                    failures++;
                    $display("FAIL exhaustive_%0d: got %h want %h", seen, cur(), e);
                end
                checks++;
                if (n !== 9) begin
                    failures++;
                    $display("FAIL exhaustive_gap_%0d: %0d cycles want 9", seen, n);
                end
                seen++;
                n = 0;
                if (next < 256) begin
                    bin = 8'(next);
                    q.push_back(expv(next));
                    next++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                bin = 8'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (seen !== 256) begin
            failures++;
            $display("FAIL exhaustive_timeout: %0d results want 256", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
